// File: rtl/uart_bus_initiator.sv
// Bus master for the UART core's 4-bit register bus: sequences host read/write cycles and
// optionally drains the receive FIFO into a one-entry valid/ready holding register.
module uart_bus_initiator #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter logic [3:0]  STATUS_ADDR   = 4'h1,
  parameter logic [3:0]  RXDATA_ADDR   = 4'h0,
  parameter int unsigned RX_EMPTY_BIT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_ReqValid_i,
  output logic       p_ReqReady_o,
  input  logic       p_ReqWrite_i,
  input  logic [3:0] ReqAddr_i,
  input  logic [7:0] ReqData_i,
  output logic       p_RspValid_o,
  output logic [7:0] RspData_o,
  input  logic       p_DrainEn_i,
  input  logic       p_IrqSig_i,
  output logic [7:0] RxByte_o,
  output logic       p_RxByteValid_o,
  input  logic       p_RxByteReady_i,
  output logic [3:0] AddrBus_o,
  output logic       n_ChipSelect_o,
  output logic       n_rd_o,
  output logic       n_we_o,
  output logic [7:0] DataBus_o,
  input  logic [7:0] DataBus_i,
  output logic       p_Busy_o
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
  typedef enum logic [1:0] {HOST, DRN_STAT, DRN_DATA} op_e;

  state_e     state, stateNext;
  op_e        op, opNext;
  logic [3:0] strobeCnt, strobeCntNext;
  logic       isWrite;
  logic       rxEmpty;
  logic       accept, drainStart, drainData, lastStrobe;

  assign lastStrobe = (state == STROBE) && (strobeCnt == 4'(STROBE_CYCLES));

  // A drain never rests in IDLE (status -> data goes HOLD -> SETUP directly),
  // so IDLE alone means no drain is in flight and the host may be accepted.
  assign p_ReqReady_o = (state == IDLE);
  assign p_Busy_o     = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    stateNext     = state;
    opNext        = op;
    strobeCntNext = strobeCnt;
    accept        = 1'b0;
    drainStart    = 1'b0;
    drainData     = 1'b0;
    unique case (state)
      IDLE: begin
        if (p_ReqValid_i) begin
          accept    = 1'b1;
          stateNext = SETUP;
          opNext    = HOST;
        end else if (p_DrainEn_i && p_IrqSig_i && !p_RxByteValid_o) begin
          drainStart = 1'b1;
          stateNext  = SETUP;
          opNext     = DRN_STAT;
        end
      end
      SETUP: begin
        stateNext     = STROBE;
        strobeCntNext = 4'd1;
      end
      STROBE: begin
        if (lastStrobe) stateNext = HOLD;
        else            strobeCntNext = strobeCnt + 4'd1;
      end
      HOLD: begin
        if (op == DRN_STAT && !rxEmpty) begin
          drainData = 1'b1;
          stateNext = SETUP;
          opNext    = DRN_DATA;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so the pins never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state          <= IDLE;
      op             <= HOST;
      strobeCnt      <= '0;
      isWrite        <= 1'b0;
      rxEmpty        <= 1'b1;
      AddrBus_o      <= '0;
      DataBus_o      <= '0;
      n_ChipSelect_o <= 1'b1;
      n_rd_o         <= 1'b1;
      n_we_o         <= 1'b1;
    end else begin
      state          <= stateNext;
      op             <= opNext;
      strobeCnt      <= strobeCntNext;
      n_ChipSelect_o <= (stateNext == IDLE);
      n_rd_o         <= !(stateNext == STROBE && !isWrite);
      n_we_o         <= !(stateNext == STROBE && isWrite);
      if (accept) begin
        isWrite   <= p_ReqWrite_i;
        AddrBus_o <= ReqAddr_i;
        if (p_ReqWrite_i) DataBus_o <= ReqData_i;
      end else if (drainStart) begin
        isWrite   <= 1'b0;
        AddrBus_o <= STATUS_ADDR;
      end else if (drainData) begin
        AddrBus_o <= RXDATA_ADDR;
      end
      if (lastStrobe && op == DRN_STAT) rxEmpty <= DataBus_i[RX_EMPTY_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_RspValid_o    <= 1'b0;
      RspData_o       <= '0;
      RxByte_o        <= '0;
      p_RxByteValid_o <= 1'b0;
    end else begin
      p_RspValid_o <= lastStrobe && (op == HOST) && !isWrite;
      if (lastStrobe && op == HOST && !isWrite) RspData_o <= DataBus_i;
      if (lastStrobe && op == DRN_DATA) begin
        RxByte_o        <= DataBus_i;
        p_RxByteValid_o <= 1'b1;
      end else if (p_RxByteValid_o && p_RxByteReady_i) begin
        p_RxByteValid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_initiator.sv
// Directed bench for uart_bus_initiator: host write/read, drain with and without data,
// host/drain arbitration and asynchronous reset during a write strobe.
`timescale 1ns/1ps
module tb_uart_bus_initiator;
  localparam int unsigned S = 2;
  localparam logic [3:0] STAT_A = 4'h1;
  localparam logic [3:0] DATA_A = 4'h0;

  logic       clk = 1'b0;
  logic       rst;
  logic       p_ReqValid_i, p_ReqReady_o, p_ReqWrite_i;
  logic [3:0] ReqAddr_i;
  logic [7:0] ReqData_i;
  logic       p_RspValid_o;
  logic [7:0] RspData_o;
  logic       p_DrainEn_i, p_IrqSig_i;
  logic [7:0] RxByte_o;
  logic       p_RxByteValid_o, p_RxByteReady_i;
  logic [3:0] AddrBus_o;
  logic       n_ChipSelect_o, n_rd_o, n_we_o;
  logic [7:0] DataBus_o, DataBus_i;
  logic       p_Busy_o;

  logic [7:0] statusVal, rxVal, hostVal;
  int checks = 0, errors = 0;
  int csLow, rdLow, weLow, rdStat, rdData, rspCnt, viol;
  logic [3:0] weAddr;
  logic [7:0] weData;
  int n;

  always #5 clk = ~clk;

  uart_bus_initiator #(.STROBE_CYCLES(S), .STATUS_ADDR(STAT_A), .RXDATA_ADDR(DATA_A), .RX_EMPTY_BIT(0)) dut (
    .clk(clk), .rst(rst),
    .p_ReqValid_i(p_ReqValid_i), .p_ReqReady_o(p_ReqReady_o), .p_ReqWrite_i(p_ReqWrite_i),
    .ReqAddr_i(ReqAddr_i), .ReqData_i(ReqData_i),
    .p_RspValid_o(p_RspValid_o), .RspData_o(RspData_o),
    .p_DrainEn_i(p_DrainEn_i), .p_IrqSig_i(p_IrqSig_i),
    .RxByte_o(RxByte_o), .p_RxByteValid_o(p_RxByteValid_o), .p_RxByteReady_i(p_RxByteReady_i),
    .AddrBus_o(AddrBus_o), .n_ChipSelect_o(n_ChipSelect_o), .n_rd_o(n_rd_o), .n_we_o(n_we_o),
    .DataBus_o(DataBus_o), .DataBus_i(DataBus_i), .p_Busy_o(p_Busy_o)
  );

  // Register-slave model: drives read data only while the read strobe is low.
  always_comb begin
    DataBus_i = 8'h00;
    if (!n_rd_o) begin
      if (AddrBus_o == STAT_A)      DataBus_i = statusVal;
      else if (AddrBus_o == DATA_A) DataBus_i = rxVal;
      else                          DataBus_i = hostVal;
    end
  end

  always @(negedge clk) begin
    if (!n_ChipSelect_o) csLow++;
    if (!n_rd_o) rdLow++;
    if (!n_we_o) begin weLow++; weAddr = AddrBus_o; weData = DataBus_o; end
    if (!n_rd_o && AddrBus_o == STAT_A) rdStat++;
    if (!n_rd_o && AddrBus_o == DATA_A) rdData++;
    if (p_RspValid_o) rspCnt++;
    if ((!n_rd_o && !n_we_o) || (n_ChipSelect_o && (!n_rd_o || !n_we_o))) viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearMon();
    csLow = 0; rdLow = 0; weLow = 0; rdStat = 0; rdData = 0; rspCnt = 0;
    weAddr = 4'hx; weData = 8'hxx;
  endtask

  // Called #1 after a clock edge; raises a request and returns #1 after its accept edge.
  task automatic hostReq(input logic wr, input logic [3:0] a, input logic [7:0] d);
    int w;
    p_ReqWrite_i = wr; ReqAddr_i = a; ReqData_i = d; p_ReqValid_i = 1'b1;
    w = 0;
    while (!p_ReqReady_o && w < 100) begin @(posedge clk); #1; w++; end
    check("req_ready_timeout", 32'(w < 100), 32'd1);
    @(posedge clk); #1;
    p_ReqValid_i = 1'b0;
  endtask

  // Called #1 after a start edge; counts cycles (start+1 = 1) until IDLE is reached.
  task automatic waitIdle(output int cyc);
    cyc = 1;
    while (p_Busy_o && cyc < 100) begin @(posedge clk); #1; cyc++; end
  endtask

  initial begin
    rst = 1'b0; viol = 0;
    p_ReqValid_i = 0; p_ReqWrite_i = 0; ReqAddr_i = 0; ReqData_i = 0;
    p_DrainEn_i = 1; p_IrqSig_i = 0; p_RxByteReady_i = 0;
    statusVal = 8'h01; rxVal = 8'h00; hostVal = 8'h00;
    clearMon();
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 32'(AddrBus_o), 32'h0);
    check("rst_data", 32'(DataBus_o), 32'h0);
    check("rst_strobes", {29'd0, n_ChipSelect_o, n_rd_o, n_we_o}, 32'h7);
    check("rst_rsp", {23'd0, p_RspValid_o, RspData_o}, 32'h0);
    check("rst_rx", {23'd0, p_RxByteValid_o, RxByte_o}, 32'h0);
    check("rst_busy", 32'(p_Busy_o), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Host write 3 <- A5
    clearMon();
    hostReq(1'b1, 4'h3, 8'hA5);
    waitIdle(n);
    check("wr_ready_again", 32'(n), 32'(S + 3));
    check("wr_ready_high", 32'(p_ReqReady_o), 32'd1);
    check("wr_cs_low", 32'(csLow), 32'(S + 2));
    check("wr_we_low", 32'(weLow), 32'(S));
    check("wr_rd_low", 32'(rdLow), 32'd0);
    check("wr_addr", 32'(weAddr), 32'h3);
    check("wr_data", 32'(weData), 32'hA5);
    check("wr_no_rsp", 32'(rspCnt), 32'd0);

    // Host read from A, slave drives 5C
    hostVal = 8'h5C;
    clearMon();
    hostReq(1'b0, 4'hA, 8'h00);
    waitIdle(n);
    check("rd_cycles", 32'(n), 32'(S + 3));
    check("rd_rd_low", 32'(rdLow), 32'(S));
    check("rd_rsp_pulses", 32'(rspCnt), 32'd1);
    check("rd_rsp_data", 32'(RspData_o), 32'h5C);
    check("rd_rxbyte_kept", {23'd0, p_RxByteValid_o, RxByte_o}, 32'h0);
    check("rd_databus_kept", 32'(DataBus_o), 32'hA5);

    // Drain with data 42, consumer stalled
    statusVal = 8'h00; rxVal = 8'h42;
    clearMon();
    p_IrqSig_i = 1'b1;
    @(posedge clk); #1;
    waitIdle(n);
    check("drn_cycles", 32'(n), 32'(2 * S + 5));
    check("drn_cs_low", 32'(csLow), 32'(2 * S + 4));
    check("drn_stat_rd", 32'(rdStat), 32'(S));
    check("drn_data_rd", 32'(rdData), 32'(S));
    check("drn_rx", {23'd0, p_RxByteValid_o, RxByte_o}, 32'h142);
    check("drn_no_rsp", 32'(rspCnt), 32'd0);
    clearMon();
    repeat (20) @(posedge clk);
    #1;
    check("drn_blocked_cs", 32'(csLow), 32'd0);
    check("drn_held", {23'd0, p_RxByteValid_o, RxByte_o}, 32'h142);
    p_IrqSig_i = 1'b0; p_RxByteReady_i = 1'b1;
    @(posedge clk); #1;
    p_RxByteReady_i = 1'b0;
    check("drn_taken", 32'(p_RxByteValid_o), 32'd0);

    // Drain with empty FIFO
    statusVal = 8'h01;
    clearMon();
    p_IrqSig_i = 1'b1;
    @(posedge clk); #1;
    p_IrqSig_i = 1'b0;
    waitIdle(n);
    check("empty_cycles", 32'(n), 32'(S + 3));
    check("empty_rd_low", 32'(rdLow), 32'(S));
    check("empty_stat_rd", 32'(rdStat), 32'(S));
    check("empty_no_byte", 32'(p_RxByteValid_o), 32'd0);

    // Host and irq in the same IDLE cycle; host then waits behind the drain
    statusVal = 8'h00; rxVal = 8'h77; hostVal = 8'h99;
    clearMon();
    p_ReqWrite_i = 1'b0; ReqAddr_i = 4'h2; p_ReqValid_i = 1'b1; p_IrqSig_i = 1'b1;
    @(posedge clk); #1;
    p_ReqValid_i = 1'b0;
    waitIdle(n);
    check("arb_host_cycles", 32'(n), 32'(S + 3));
    check("arb_host_rsp", 32'(RspData_o), 32'h99);
    check("arb_no_stat_yet", 32'(rdStat), 32'd0);
    @(posedge clk); #1;
    p_IrqSig_i = 1'b0;
    check("arb_drain_started", {27'd0, p_Busy_o, AddrBus_o}, {27'd1, STAT_A});
    @(posedge clk); #1;
    p_ReqWrite_i = 1'b1; ReqAddr_i = 4'h5; ReqData_i = 8'h3C; p_ReqValid_i = 1'b1;
    n = 0;
    while (!p_ReqReady_o && n < 100) begin @(posedge clk); #1; n++; end
    check("arb_host_wait", 32'(n), 32'(2 * S + 3));
    check("arb_data_rd", 32'(rdData), 32'(S));
    check("arb_rx", {23'd0, p_RxByteValid_o, RxByte_o}, 32'h177);
    @(posedge clk); #1;
    p_ReqValid_i = 1'b0;
    waitIdle(n);
    check("arb_wr_addr", 32'(weAddr), 32'h5);
    check("arb_wr_data", 32'(weData), 32'h3C);
    check("arb_rsp_total", 32'(rspCnt), 32'd1);

    // Asynchronous reset during the write strobe
    hostReq(1'b1, 4'h6, 8'hF0);
    n = 0;
    while (n_we_o && n < 20) begin @(posedge clk); #1; n++; end
    check("rst_we_reached", 32'(n_we_o), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_strobes", {29'd0, n_ChipSelect_o, n_rd_o, n_we_o}, 32'h7);
    check("arst_bus", {20'd0, AddrBus_o, DataBus_o}, 32'h0);
    check("arst_rx", {23'd0, p_RxByteValid_o, RxByte_o}, 32'h0);
    check("arst_rsp_busy", {22'd0, p_Busy_o, p_RspValid_o, RspData_o}, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    hostVal = 8'hC3;
    clearMon();
    hostReq(1'b0, 4'h9, 8'h00);
    waitIdle(n);
    check("post_rst_cycles", 32'(n), 32'(S + 3));
    check("post_rst_rsp", {23'd0, 1'b0, RspData_o} | 32'(rspCnt << 8), 32'h1C3);

    check("protocol_viol", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
